// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one byte per frame (start, DBIT data bits
// LSB first, optional even parity, stop) at 16 tx_tick pulses per bit.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, waiting for tx_start
// START  | start bit (tdo=0) for 16 ticks
// DATA   | DBIT data bits, 16 ticks each, shift register shifts right
// PARITY | even-parity bit for 16 ticks (only when PARITY_EN=1)
// STOP   | line high for SB_TICK ticks, tx_done on the last one
module uart_transmitter #(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int PARITY_EN = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_tick,
  input  logic       tx_start,
  input  logic [7:0] data_tx,
  output logic       tdo,
  output logic       tx_busy,
  output logic       tx_done
);

  // Tick counter normally spans one bit (0..15); it widens only when the
  // stop period is longer than a bit so it can count the whole stop time.
  localparam int TICK_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(15);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [2:0]        DBIT_LAST = 3'(DBIT - 1);
  localparam logic [7:0]        DATA_MASK = 8'((1 << DBIT) - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  tx_state_t         state_q, state_n;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shift_reg, shift_reg_n;
  logic              parity_q, parity_n;
  logic              tdo_q, tdo_n;
  logic              done_q, done_n;

  // State and datapath registers; reset forces the line idle-high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity_q  <= 1'b0;
      tdo_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      tick_cnt  <= tick_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_reg_n;
      parity_q  <= parity_n;
      tdo_q     <= tdo_n;
      done_q    <= done_n;
    end
  end

  // Next-state and next-output logic; everything holds unless a tick or an
  // accepted start request moves it.
  always_comb begin
    state_n     = state_q;
    tick_cnt_n  = tick_cnt;
    bit_cnt_n   = bit_cnt;
    shift_reg_n = shift_reg;
    parity_n    = parity_q;
    tdo_n       = tdo_q;
    done_n      = 1'b0;

    case (state_q)
      IDLE: begin
        // A tick arriving with the start request is deliberately not counted.
        if (tx_start) begin
          shift_reg_n = data_tx & DATA_MASK;
          parity_n    = ^(data_tx & DATA_MASK);
          tick_cnt_n  = '0;
          bit_cnt_n   = '0;
          tdo_n       = 1'b0;
          state_n     = START;
        end
      end

      START: begin
        if (tx_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_n = '0;
            tdo_n      = shift_reg[0];
            state_n    = DATA;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (tx_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_n  = '0;
            shift_reg_n = shift_reg >> 1;
            bit_cnt_n   = bit_cnt + 1'b1;
            if (bit_cnt == DBIT_LAST) begin
              if (PARITY_EN != 0) begin
                tdo_n   = parity_q;
                state_n = PARITY;
              end else begin
                tdo_n   = 1'b1;
                state_n = STOP;
              end
            end else begin
              tdo_n = shift_reg[1];
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      PARITY: begin
        if (tx_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_n = '0;
            tdo_n      = 1'b1;
            state_n    = STOP;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (tx_tick) begin
          if (tick_cnt == STOP_LAST) begin
            tick_cnt_n = '0;
            done_n     = 1'b1;
            state_n    = IDLE;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      default: begin
        tdo_n   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  assign tdo     = tdo_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three instances (default, even
// parity, DBIT=7 with two stop bits) share clock, tick and reset.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_tick = 1'b0;
  logic [2:0] tx_start = '0;
  logic [7:0] data_tx [3];
  logic [2:0] tdo, tx_busy, tx_done;

  int n_chk = 0;
  int n_pass = 0;

  // frame monitor state
  int         cyc = 0;
  bit         act [3];
  int         scyc [3];
  int         bidx [3];
  logic [15:0] acc [3];
  logic [15:0] frm [3][8];
  int         nfrm [3];
  int         done_cnt [3];
  int         busy_ticks [3];
  int         last_done [3];
  int         prev_done [3];

  uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .tx_tick(tx_tick), .tx_start(tx_start[0]),
    .data_tx(data_tx[0]), .tdo(tdo[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

  uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .tx_tick(tx_tick), .tx_start(tx_start[1]),
    .data_tx(data_tx[1]), .tdo(tdo[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

  uart_transmitter #(.DBIT(7), .SB_TICK(32), .PARITY_EN(0)) u_dut2 (
    .clk(clk), .reset(rst_n), .tx_tick(tx_tick), .tx_start(tx_start[2]),
    .data_tx(data_tx[2]), .tdo(tdo[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

  initial forever #5 clk = ~clk;

  // tick every 4th clk, changed 1 time unit after the rising edge
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      tx_tick = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  function automatic int nbits(int i);
    case (i)
      0: return 10;
      1: return 11;
      default: return 10;
    endcase
  endfunction

  // Mid-bit sampler: a frame is captured LSB-first (bit 0 = start bit).
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        act[i] = 1'b0;
      end else begin
        if (tx_busy[i] && tx_tick) busy_ticks[i]++;
        if (tx_done[i]) begin
          done_cnt[i]++;
          prev_done[i] = last_done[i];
          last_done[i] = cyc;
        end
        if (!act[i]) begin
          if (tdo[i] == 1'b0) begin
            act[i]  = 1'b1;
            scyc[i] = cyc;
            bidx[i] = 0;
            acc[i]  = '0;
          end
        end else if (cyc - scyc[i] == 32 + 64 * bidx[i]) begin
          acc[i][bidx[i]] = tdo[i];
          bidx[i]++;
          if (bidx[i] == nbits(i)) begin
            if (nfrm[i] < 8) frm[i][nfrm[i]] = acc[i];
            nfrm[i]++;
            act[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      done_cnt[i]   = 0;
      busy_ticks[i] = 0;
      nfrm[i]       = 0;
    end
  endtask

  // start request placed in a cycle that also carries a tick
  task automatic send(input int i, input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_tick && n < 8) begin
      step();
      n++;
    end
    data_tx[i]  = d;
    tx_start[i] = 1'b1;
    step();
    tx_start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string tag);
    int n;
    n = 0;
    while (!tx_done[i] && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) chk_eq(tag, 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      data_tx[i] = 8'h00;
      act[i] = 1'b0;
      last_done[i] = 0;
      prev_done[i] = 0;
    end
    clr();

    // reset state
    #13;
    chk_eq("rst_tdo0", 32'(tdo[0]), 32'd1);
    chk_eq("rst_busy0", 32'(tx_busy[0]), 32'd0);
    chk_eq("rst_done0", 32'(tx_done[0]), 32'd0);
    chk_eq("rst_tdo2", 32'(tdo[2]), 32'd1);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // plain 0xA5, start coincident with a tick
    clr();
    send(0, 8'hA5);
    wait_done(0, "a5_timeout");
    repeat (3) step();
    chk_eq("a5_nfrm", 32'(nfrm[0]), 32'd1);
    chk_eq("a5_frame", 32'(frm[0][0]), 32'h34A);
    chk_eq("a5_done", 32'(done_cnt[0]), 32'd1);
    chk_eq("a5_ticks", 32'(busy_ticks[0]), 32'd160);
    chk_eq("a5_idle", 32'(tx_busy[0]), 32'd0);

    // start request mid-frame is ignored
    clr();
    send(0, 8'hA5);
    repeat (200) step();
    data_tx[0]  = 8'h3C;
    tx_start[0] = 1'b1;
    step();
    tx_start[0] = 1'b0;
    wait_done(0, "mid_timeout");
    repeat (700) step();
    chk_eq("mid_nfrm", 32'(nfrm[0]), 32'd1);
    chk_eq("mid_frame", 32'(frm[0][0]), 32'h34A);
    chk_eq("mid_done", 32'(done_cnt[0]), 32'd1);

    // back-to-back frames with tx_start held high
    clr();
    data_tx[0]  = 8'h55;
    tx_start[0] = 1'b1;
    wait_done(0, "b2b_timeout1");
    data_tx[0] = 8'hAA;
    step();
    chk_eq("b2b_accept", 32'(tx_busy[0]), 32'd1);
    tx_start[0] = 1'b0;
    wait_done(0, "b2b_timeout2");
    repeat (3) step();
    chk_eq("b2b_nfrm", 32'(nfrm[0]), 32'd2);
    chk_eq("b2b_frame0", 32'(frm[0][0]), 32'h2AA);
    chk_eq("b2b_frame1", 32'(frm[0][1]), 32'h354);
    chk_eq("b2b_spacing", 32'(last_done[0] - prev_done[0]), 32'd640);
    chk_eq("b2b_ticks", 32'(busy_ticks[0]), 32'd320);
    chk_eq("b2b_done", 32'(done_cnt[0]), 32'd2);

    // even parity
    clr();
    send(1, 8'h07);
    wait_done(1, "par07_timeout");
    repeat (3) step();
    chk_eq("par07_frame", 32'(frm[1][0]), 32'h60E);
    chk_eq("par07_ticks", 32'(busy_ticks[1]), 32'd176);
    send(1, 8'h03);
    wait_done(1, "par03_timeout");
    repeat (3) step();
    chk_eq("par03_frame", 32'(frm[1][1]), 32'h406);
    chk_eq("par_nfrm", 32'(nfrm[1]), 32'd2);

    // 7 data bits, 32-tick stop
    clr();
    send(2, 8'h7F);
    wait_done(2, "d7_timeout");
    repeat (3) step();
    chk_eq("d7_frame", 32'(frm[2][0]), 32'h3FE);
    chk_eq("d7_ticks", 32'(busy_ticks[2]), 32'd160);
    send(2, 8'h85);
    wait_done(2, "d7b_timeout");
    repeat (3) step();
    chk_eq("d7_mask", 32'(frm[2][1]), 32'h30A);
    chk_eq("d7_done", 32'(done_cnt[2]), 32'd2);

    // reset during data bit 3, then a clean 0x81
    clr();
    send(0, 8'hA5);
    repeat (290) step();
    chk_eq("abort_bit3", 32'(tdo[0]), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_eq("abort_tdo", 32'(tdo[0]), 32'd1);
    chk_eq("abort_busy", 32'(tx_busy[0]), 32'd0);
    repeat (3) step();
    chk_eq("abort_done", 32'(done_cnt[0]), 32'd0);
    chk_eq("abort_nfrm", 32'(nfrm[0]), 32'd0);
    rst_n       = 1'b1;
    data_tx[0]  = 8'h81;
    tx_start[0] = 1'b1;
    step();
    chk_eq("post_rst_accept", 32'(tx_busy[0]), 32'd1);
    tx_start[0] = 1'b0;
    wait_done(0, "post_rst_timeout");
    repeat (3) step();
    chk_eq("post_rst_frame", 32'(frm[0][0]), 32'h302);
    chk_eq("post_rst_done", 32'(done_cnt[0]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter SB_TICK, default 16, stop-bit length in tx_tick pulses (16 = 1 stop bit, 32 = 2).
REQ-003 SHALL have parameter PARITY_EN, default 0; 1 inserts an even-parity bit after the data bits.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port tx_tick  input  1  one-clk-wide pulse at 16x baud, from the same baud generator that drives the receiver's rx_tick.
REQ-007 SHALL have port tx_start  input  1  request to send data_tx; sampled only in IDLE.
REQ-008 SHALL have port data_tx  input  8  byte to send; only bits [DBIT-1:0] are used.
REQ-009 SHALL have port tdo  output  1  serial line: idle high, LSB first.
REQ-010 SHALL have port tx_busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port tx_done  output  1  one-clk pulse when a frame's stop period completes.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, plus registers for a 4-bit tick counter, 3-bit bit counter, 8-bit shift register and a registered tdo.
REQ-013 In IDLE with tx_start=1 at a clk edge, SHALL latch data_tx into the shift register, clear both counters, go to START and drive tdo=0 from that edge on.
REQ-014 SHALL ignore tx_start outside IDLE; a new data_tx value SHALL NOT alter a frame in progress.
REQ-015 SHALL change the tick counter only on clk edges where tx_tick=1; clk edges without a tick hold all state.
REQ-016 START: on the tick at which the counter equals 15, SHALL clear the counter, go to DATA and drive tdo=shift[0]; otherwise increment the counter.
REQ-017 DATA: each bit SHALL last 16 ticks; at counter=15 SHALL shift right, increment the bit counter and drive tdo with the next bit.
REQ-018 DATA exit: after bit DBIT-1 completes, SHALL go to PARITY with tdo = XOR of the sent data bits if PARITY_EN=1, else go to STOP with tdo=1.
REQ-019 PARITY SHALL last 16 ticks, then go to STOP with tdo=1.
REQ-020 STOP SHALL hold tdo=1 for SB_TICK ticks; on the final tick SHALL go to IDLE and assert tx_done for exactly that one clk.
REQ-021 Bit time SHALL be exactly 16 tx_tick pulses; frame length SHALL be 16*(1+DBIT+PARITY_EN)+SB_TICK ticks.
REQ-022 tx_start SHALL be accepted in the clk cycle after tx_done, giving back-to-back frames with no idle bit.
REQ-023 tx_tick and tx_start arriving in the same cycle in IDLE SHALL start the frame; that tick SHALL NOT be counted toward the start bit.
REQ-024 tdo SHALL come directly from a register (no combinational glitches).

Reset
REQ-025 While reset=0, regardless of clk, SHALL force state=IDLE, tdo=1, tx_busy=0, tx_done=0, and counters and shift register to 0.
REQ-026 Reset asserted mid-frame SHALL drive tdo=1 immediately; no tx_done SHALL be produced for the aborted frame.
REQ-027 After reset deasserts, the first tx_start SHALL be accepted on the next clk edge.

Verification
REQ-028 Default params, tick every 4 clk, send 0xA5 -> tdo = 0, 1,0,1,0,0,1,0,1, 1; each bit 16 ticks (64 clk); tx_done one pulse; tx_busy high for 160 ticks.
REQ-029 PARITY_EN=1, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame length 176 ticks.
REQ-030 Pulse tx_start with 0x3C mid-frame of 0xA5 -> 0xA5 frame unchanged, 0x3C never sent, single tx_done.
REQ-031 Hold tx_start high with 0x55 then 0xAA -> two frames with no idle gap; tx_done pulses 160 ticks apart.
REQ-032 Assert reset during data bit 3 -> tdo=1 without waiting for clk, tx_busy=0, no tx_done; next 0x81 is sent correctly.
REQ-033 SB_TICK=32, DBIT=7, send 0x7F -> 7 data bits of 1, stop held 32 ticks, total 160 ticks; loopback into uart_receiver returns 0x7F.
